// File: rtl/ahb_data_memory.sv
// AHB-Lite subordinate in front of a word-organised data SRAM: zero-wait
// legal transfers, two-cycle ERROR response for out-of-range/misaligned/oversized ones.
module ahb_data_memory #(
  parameter int MEM_DEPTH = 32768
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int WW = AW - 2;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  logic [31:0] mem [MEM_DEPTH/4];

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic          write_q, write_d;
  logic [3:0]    mask_q, mask_d;
  logic [WW-1:0] widx_q, widx_d;

  logic       accept;
  logic       legal;
  logic [3:0] lane_mask;

  // Legality and little-endian lane selection for the address phase on the bus.
  always_comb begin
    lane_mask = 4'b0000;
    legal     = 1'b0;
    case (HSIZE)
      3'd0: begin
        lane_mask = 4'b0001 << HADDR[1:0];
        legal     = 1'b1;
      end
      3'd1: begin
        lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
        legal     = ~HADDR[0];
      end
      3'd2: begin
        lane_mask = 4'b1111;
        legal     = (HADDR[1:0] == 2'b00);
      end
      default: begin
        lane_mask = 4'b0000;
        legal     = 1'b0;
      end
    endcase
    if (HADDR >= 32'(MEM_DEPTH)) legal = 1'b0;
  end

  assign accept = HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11) && (state_q != ST_ERR1);

  // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    write_d = write_q;
    mask_d  = mask_q;
    widx_d  = widx_q;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      ST_OKAY, ST_ERR2: begin
        state_d = ST_OKAY;
        if (accept) begin
          if (legal) begin
            valid_d = 1'b1;
            write_d = HWRITE;
            mask_d  = lane_mask;
            widx_d  = HADDR[AW-1:2];
          end else begin
            state_d = ST_ERR1;
          end
        end
      end
      default: state_d = ST_OKAY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_OKAY;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      mask_q  <= 4'b0000;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      write_q <= write_d;
      mask_q  <= mask_d;
      widx_q  <= widx_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive HRESETn and are preloaded externally.
  always_ff @(posedge HCLK) begin
    if (valid_q && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[widx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (valid_q && !write_q) HRDATA = mem[widx_q];
  end

  assign HREADYOUT = (state_q != ST_ERR1);
  assign HRESP     = (state_q != ST_OKAY);

endmodule

// File: tb/tb_ahb_data_memory.sv
// Directed plus randomized bench for ahb_data_memory against a byte-array
// model of the memory and a cycle-count model of the ERROR response.
module tb_ahb_data_memory;

  localparam int MEM_DEPTH = 32768;
  localparam int PRELOAD_WORDS = 256;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  ahb_data_memory #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          valid;
    bit          write;
    int unsigned addr;
    int unsigned size;
    logic [31:0] wdata;
  } xfer_t;

  logic [7:0] ref_bytes [MEM_DEPTH];
  xfer_t      pend;
  int         err_left;   // 2 = first error cycle, 1 = second, 0 = none
  int         passed;
  int         total;
  int         failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int unsigned a);
    int unsigned b;
    b = a - (a % 4);
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  function automatic bit is_legal(input int unsigned addr, input int unsigned size);
    if (addr >= MEM_DEPTH) return 1'b0;
    if (size > 2) return 1'b0;
    return (addr % (1 << size)) == 0;
  endfunction

  task automatic model_write(input int unsigned addr, input int unsigned size, input logic [31:0] wdata);
    for (int b = 0; b < (1 << size); b++) begin
      int unsigned a;
      a = addr + b;
      ref_bytes[a] = wdata[8*(a%4) +: 8];
    end
  endtask

  // One bus cycle: check the current data phase, present a new address phase, advance one edge.
  task automatic step(input logic [1:0] trans, input int unsigned addr, input int unsigned size,
                      input bit wr, input logic [31:0] wdata, input string tag);
    logic        exp_ready;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    exp_ready = (err_left != 2);
    exp_resp  = (err_left != 0);
    exp_rdata = (err_left == 0 && pend.valid && !pend.write) ? model_word(pend.addr) : 32'h0;
    check({tag, "/hreadyout"}, {31'h0, HREADYOUT}, {31'h0, exp_ready});
    check({tag, "/hresp"}, {31'h0, HRESP}, {31'h0, exp_resp});
    check({tag, "/hrdata"}, HRDATA, exp_rdata);

    HTRANS = trans;
    HADDR  = addr;
    HSIZE  = size[2:0];
    HWRITE = wr;
    HREADY = exp_ready;
    HWDATA = (pend.valid && pend.write) ? pend.wdata : $urandom;

    if (err_left == 0 && pend.valid && pend.write) model_write(pend.addr, pend.size, pend.wdata);
    if (err_left == 2) begin
      err_left   = 1;
      pend.valid = 1'b0;
    end else begin
      err_left   = 0;
      pend.valid = 1'b0;
      if (exp_ready && trans[1]) begin
        if (is_legal(addr, size)) begin
          pend.valid = 1'b1;
          pend.write = wr;
          pend.addr  = addr;
          pend.size  = size;
          pend.wdata = wdata;
        end else begin
          err_left = 2;
        end
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 0, 2, 1'b0, 32'h0, "idle");
  endtask

  initial begin
    logic [31:0] v;
    passed = 0; total = 0; failed = 0;
    err_left = 0;
    pend = '{valid: 1'b0, write: 1'b0, addr: 0, size: 0, wdata: 32'h0};
    HRESETn = 1'b1;
    HTRANS = 2'b00; HADDR = 32'h0; HSIZE = 3'd2; HWRITE = 1'b0;
    HWDATA = 32'h0; HREADY = 1'b1;
    for (int i = 0; i < MEM_DEPTH; i++) ref_bytes[i] = 8'h00;
    for (int i = 0; i < PRELOAD_WORDS; i++) begin
      v = (i == 5) ? 32'hCAFEF00D : $urandom;
      dut.mem[i] <= v;
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = v[8*b +: 8];
    end

    // Reset then IDLE
    #1 HRESETn = 1'b0;
    #1;
    check("reset/hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("reset/hresp", {31'h0, HRESP}, 32'h0);
    check("reset/hrdata", HRDATA, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    idle(3);

    // Word write then read, plus preloaded word
    step(2'b10, 32'h10, 2, 1'b1, 32'hDEADBEEF, "t2_wr");
    step(2'b10, 32'h10, 2, 1'b0, 32'h0, "t2_rd");
    check("t2/const_rdata", HRDATA, 32'hDEADBEEF);
    step(2'b10, 32'h14, 2, 1'b0, 32'h0, "t2_rd_pre");
    check("t2/preload_rdata", HRDATA, 32'hCAFEF00D);
    idle(1);

    // Byte and halfword lanes
    step(2'b10, 32'h10, 2, 1'b1, 32'h11223344, "t3_init");
    step(2'b10, 32'h12, 0, 1'b1, 32'h00AB0000, "t3_byte");
    step(2'b10, 32'h10, 2, 1'b0, 32'h0, "t3_rd1");
    check("t3/byte_lane", HRDATA, 32'h11AB3344);
    step(2'b10, 32'h10, 1, 1'b1, 32'h0000CDEF, "t3_half");
    step(2'b10, 32'h10, 2, 1'b0, 32'h0, "t3_rd2");
    check("t3/half_lane", HRDATA, 32'h11ABCDEF);
    idle(1);

    // Pipelined stream: four writes then four reads back to back
    for (int i = 0; i < 4; i++)
      step(i == 0 ? 2'b10 : 2'b11, 32'h20 + 4*i, 2, 1'b1, i + 1, "t4_wr");
    step(2'b10, 32'h20, 2, 1'b0, 32'h0, "t4_rd");
    for (int i = 1; i <= 4; i++) begin
      check("t4/stream_rdata", HRDATA, i);
      check("t4/stream_ready", {31'h0, HREADYOUT}, 32'h1);
      if (i < 4) step(2'b11, 32'h20 + 4*i, 2, 1'b0, 32'h0, "t4_rd");
      else step(2'b00, 0, 2, 1'b0, 32'h0, "t4_end");
    end

    // Error responses
    step(2'b10, 32'h8000, 2, 1'b0, 32'h0, "t5_oor");
    check("t5/err1_ready", {31'h0, HREADYOUT}, 32'h0);
    check("t5/err1_resp", {31'h0, HRESP}, 32'h1);
    step(2'b10, 32'h30, 2, 1'b1, 32'h12345678, "t5_in_err1");
    check("t5/err2_ready", {31'h0, HREADYOUT}, 32'h1);
    check("t5/err2_resp", {31'h0, HRESP}, 32'h1);
    idle(2);
    step(2'b10, 32'h02, 2, 1'b1, 32'hFFFFFFFF, "t5_mis");
    idle(3);
    step(2'b10, 32'h00, 2, 1'b0, 32'h0, "t5_rd0");
    step(2'b10, 32'h30, 2, 1'b0, 32'h0, "t5_rd30");
    idle(1);

    // Reset during a write data phase
    step(2'b10, 32'h40, 2, 1'b1, 32'h55, "t6_wr");
    HTRANS = 2'b00;
    HWDATA = 32'h55;
    HRESETn = 1'b0;
    #1;
    check("t6/rst_ready", {31'h0, HREADYOUT}, 32'h1);
    check("t6/rst_resp", {31'h0, HRESP}, 32'h0);
    check("t6/rst_rdata", HRDATA, 32'h0);
    pend.valid = 1'b0;
    err_left = 0;
    @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    step(2'b10, 32'h40, 2, 1'b0, 32'h0, "t6_rd");
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned r, size, addr;
      logic [1:0] trans;
      r = $urandom_range(0, 9);
      trans = (r < 2) ? 2'b00 : (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      size = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
      addr = $urandom_range(0, 4*PRELOAD_WORDS - 1);
      if (size <= 2 && $urandom_range(0, 3) != 0) addr = addr - (addr % (1 << size));
      if ($urandom_range(0, 14) == 0) addr = MEM_DEPTH + $urandom_range(0, 32'hFFFF);
      step(trans, addr, size, $urandom_range(0, 1) == 1, $urandom, "rand");
    end
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
